// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: arbiter state encoding and the pipeline-wide NOP instruction
package rv_mem_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    I_DRAIN = 2'd3
  } arb_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts busy cycles without ack and strobes expire when the limit is reached
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  // the cycle whose increment would reach TIMEOUT is the last one allowed
  assign expire = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one variable-latency memory between fetch and load/store
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);
  arb_state_t state, state_n;
  logic d_next, if_elig, d_elig, pick_d, grant, expire, finish, deliver_i, deliver_d;
  // a requester is not eligible in the cycle its completion pulse is out
  assign if_elig = if_req & ~if_valid;
  assign d_elig  = d_req & ~d_valid;
  assign pick_d  = d_elig & (~if_elig | d_next);
  assign grant   = (state == IDLE) & (if_elig | d_elig);
  assign stall   = if_elig | d_elig;
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(grant),
    .en((state != IDLE) & ~mem_ack),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    finish    = 1'b0;
    deliver_i = 1'b0;
    deliver_d = 1'b0;
    case (state)
      IDLE: if (grant) state_n = pick_d ? D_BUSY : I_BUSY;
      I_BUSY:
        if (mem_ack | expire) begin
          state_n   = IDLE;
          finish    = 1'b1;
          deliver_i = ~if_flush;
        end else if (if_flush) state_n = I_DRAIN;
      D_BUSY:
        if (mem_ack | expire) begin
          state_n   = IDLE;
          finish    = 1'b1;
          deliver_d = 1'b1;
        end
      I_DRAIN:
        if (mem_ack | expire) begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  // on timeout the owner still gets a pulse: NOP for fetch, zero for data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      d_next      <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= deliver_i;
      d_valid  <= deliver_d;
      if (deliver_i) if_rdata <= mem_ack ? mem_rdata : DATA_W'(NOP);
      if (deliver_d && !(mem_ack && mem_we)) d_rdata <= mem_ack ? mem_rdata : '0;
      if (expire) timeout_err <= 1'b1;
      if (grant) begin
        mem_req   <= 1'b1;
        mem_we    <= pick_d & d_we;
        mem_addr  <= pick_d ? d_addr : if_addr;
        mem_wdata <= pick_d ? d_wdata : '0;
        if (if_elig & d_elig) d_next <= ~pick_d;
      end else if (finish) mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tables, hand sequences and a randomized transaction-level model
module tb_mem_port_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req = 0, if_flush = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_valid, d_valid, mem_req, mem_we, stall, timeout_err;
  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ireq, flush, dreq, dwe, ack;
    logic [31:0] rd;
    logic e_req, e_we, e_iv, e_dv, e_stall;
    logic [31:0] e_addr, e_ird;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {if_req, if_flush, d_req, d_we, mem_ack} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // transaction-level reference state for the random phase
  bit m_act, m_own_d, m_we, m_ptr_d, m_iv, m_dv, m_err, piv, pdv, ie, de;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  int m_age, mcnt, ack_at;

  task automatic m_done(input bit acked);
    if (!m_own_d) begin
      m_iv  = 1;
      m_ird = acked ? mem_rdata : NOP_I;
    end else begin
      m_dv = 1;
      if (!(acked && m_we)) m_drd = acked ? mem_rdata : 32'h0;
    end
    m_act = 0;
  endtask

  initial begin
    tbl = '{
      '{1,0,0,0,0, 32'h0,        0,0,0,0,1, 32'h0,   32'h0},
      '{1,0,0,0,0, 32'h0,        1,0,0,0,1, 32'h4,   32'h0},
      '{1,0,0,0,0, 32'h0,        1,0,0,0,1, 32'h4,   32'h0},
      '{1,0,0,0,1, 32'h00500093, 1,0,0,0,1, 32'h4,   32'h0},
      '{1,0,0,0,0, 32'h0,        0,0,1,0,0, 32'h0,   32'h00500093},
      '{0,0,0,0,0, 32'h0,        0,0,0,0,0, 32'h0,   32'h00500093},
      '{0,0,1,1,0, 32'h0,        0,0,0,0,1, 32'h0,   32'h00500093},
      '{0,0,1,1,0, 32'h0,        1,1,0,0,1, 32'h100, 32'h00500093},
      '{0,0,1,1,1, 32'h0BADF00D, 1,1,0,0,1, 32'h100, 32'h00500093},
      '{0,0,1,1,0, 32'h0,        0,0,0,1,0, 32'h0,   32'h00500093},
      '{0,0,0,0,0, 32'h0,        0,0,0,0,0, 32'h0,   32'h00500093},
      '{1,0,0,0,0, 32'h0,        0,0,0,0,1, 32'h0,   32'h00500093},
      '{1,0,0,0,0, 32'h0,        1,0,0,0,1, 32'h4,   32'h00500093},
      '{1,1,0,0,0, 32'h0,        1,0,0,0,1, 32'h4,   32'h00500093},
      '{1,0,0,0,0, 32'h0,        1,0,0,0,1, 32'h4,   32'h00500093},
      '{1,0,0,0,1, 32'hBAD0BAD0, 1,0,0,0,1, 32'h4,   32'h00500093},
      '{1,0,0,0,0, 32'h0,        0,0,0,0,1, 32'h0,   32'h00500093},
      '{1,0,0,0,1, 32'h00000093, 1,0,0,0,1, 32'h4,   32'h00500093},
      '{1,0,0,0,0, 32'h0,        0,0,1,0,0, 32'h0,   32'h00000093},
      '{0,0,0,0,0, 32'h0,        0,0,0,0,0, 32'h0,   32'h00000093}
    };
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // fetch latency, store, flushed fetch
    if_addr = 32'h4; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {if_req, if_flush, d_req, d_we, mem_ack} = {tbl[i].ireq, tbl[i].flush, tbl[i].dreq, tbl[i].dwe, tbl[i].ack};
      mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
        if (tbl[i].e_we) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, 32'hDEADBEEF);
      end
      chk($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].e_iv);
      chk($sformatf("tbl%0d_d_valid", i), d_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_ird);
      chk($sformatf("tbl%0d_d_rdata", i), d_rdata, 32'h0);
    end

    // round-robin: D first after reset, then I, next contention goes to I
    do_reset();
    if_addr = 32'h40; d_addr = 32'h200; d_we = 0; if_req = 1; d_req = 1;
    @(negedge clk); #1;
    chk("rr_first_req", mem_req, 1);
    chk("rr_first_d", mem_addr, 32'h200);
    mem_ack = 1; mem_rdata = 32'h11;
    @(negedge clk); mem_ack = 0; #1;
    chk("rr_d_valid", d_valid, 1);
    chk("rr_d_rdata", d_rdata, 32'h11);
    d_req = 0;
    @(negedge clk); #1;
    chk("rr_then_i", mem_addr, 32'h40);
    mem_ack = 1; mem_rdata = 32'h22;
    @(negedge clk); mem_ack = 0; #1;
    chk("rr_i_valid", if_valid, 1);
    chk("rr_i_rdata", if_rdata, 32'h22);
    if_req = 0;
    @(negedge clk);
    if_addr = 32'h44; d_addr = 32'h204; if_req = 1; d_req = 1;
    @(negedge clk); #1;
    chk("rr_second_i", mem_addr, 32'h44);

    // hung memory times out after TO busy cycles
    do_reset();
    if_addr = 32'h80; if_req = 1;
    for (int n = 1; n <= TO + 1; n++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo_req_c%0d", n), mem_req, n <= TO);
      if (n == TO) chk("tmo_err_early", timeout_err, 0);
    end
    chk("tmo_if_valid", if_valid, 1);
    chk("tmo_nop", if_rdata, NOP_I);
    chk("tmo_err", timeout_err, 1);
    if_req = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_err_sticky", timeout_err, 1);
    chk("tmo_idle", mem_req, 0);

    // asynchronous reset in the middle of a data access
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h300;
    @(negedge clk); #1;
    chk("arst_busy", mem_req, 1);
    #2 rst = 0; #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_d_valid", d_valid, 0);
    chk("arst_err", timeout_err, 0);
    d_req = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    chk("arst_idle", mem_req, 0);
    d_req = 1;
    @(negedge clk); #1;
    chk("arst_regrant", mem_req, 1);
    chk("arst_addr", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'h5A5A;
    @(negedge clk); mem_ack = 0; #1;
    chk("arst_d_valid2", d_valid, 1);
    chk("arst_d_rdata", d_rdata, 32'h5A5A);
    d_req = 0;

    // random traffic against the transaction model
    do_reset();
    m_act = 0; m_ptr_d = 1; m_iv = 0; m_dv = 0; m_err = 0; m_ird = 0; m_drd = 0; mcnt = 0; ack_at = 1;
    for (int s = 0; s < 3000; s++) begin
      @(negedge clk);
      piv = m_iv; pdv = m_dv; m_iv = 0; m_dv = 0;
      if (m_act) begin
        if (mem_ack) m_done(1);
        else begin
          m_age++;
          if (m_age == TO) begin
            m_err = 1;
            m_done(0);
          end
        end
      end else begin
        ie = if_req & ~piv;
        de = d_req & ~pdv;
        if (ie | de) begin
          m_own_d = de & (~ie | m_ptr_d);
          if (ie & de) m_ptr_d = ~m_own_d;
          m_act = 1; m_age = 0;
          m_addr = m_own_d ? d_addr : if_addr;
          m_we = m_own_d & d_we;
          m_wdata = m_own_d ? d_wdata : 32'h0;
        end
      end
      chk("rnd_mem_req", mem_req, m_act);
      if (m_act) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_we);
        chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_if_valid", if_valid, m_iv);
      chk("rnd_d_valid", d_valid, m_dv);
      chk("rnd_if_rdata", if_rdata, m_ird);
      chk("rnd_d_rdata", d_rdata, m_drd);
      chk("rnd_err", timeout_err, m_err);
      if (if_req && m_iv) if_req = 0;
      if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && m_dv) d_req = 0;
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1;
        d_we = $urandom_range(1);
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end
      if (mem_req) begin
        mcnt++;
        mem_ack = (mcnt == ack_at);
      end else begin
        mcnt = 0;
        ack_at = $urandom_range(10, 1);
        mem_ack = ($urandom_range(7) == 0);
      end
      mem_rdata = $urandom;
      #1;
      chk("rnd_stall", stall, (if_req & ~m_iv) | (d_req & ~m_dv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
